// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and the SPI slave bench: opcodes,
// frame geometry and the master FSM state encoding.
package spi_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_SHIFT,
        ST_HOLD,
        ST_RD_WAIT,
        ST_RD_SHIFT,
        ST_GAP
    } spi_master_state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with parallel load, serial in at the LSB and
// serial out at the MSB. Cleared by reset so an idle serial line reads 0.
module spi_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              shift_en,
    input  logic              sin,
    output logic              sout,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_val;
        end else if (shift_en) begin
            sr_d = {sr_q[DATA_W-2:0], sin};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sout = sr_q[DATA_W-1];
    assign q    = sr_q;

endmodule

// File: rtl/spi_master.sv
// SPI master: turns a 10-bit host command into the slave's framing and, for
// read-data frames, collects the returned byte from MISO.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] din,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int WAIT_MAX = (RD_LAT > IDLE_GAP) ? RD_LAT : IDLE_GAP;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    spi_master_state_t state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]        op_q, op_d;
    logic              pending_q, pending_d;
    logic              ss_n_q, ss_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_valid_d;

    logic              reject;
    logic              tx_load;
    logic              tx_shift;
    logic              rx_shift;
    logic [FRAME_BITS-1:0] tx_par_unused;
    logic              rx_sout_unused;

    // The slave picks READ_ADD vs READ_DATA from its own flag, so a read
    // opcode that disagrees with that flag would desynchronise the pair.
    assign reject = ((din[9:8] == OP_RD_DATA) && !pending_q) ||
                    ((din[9:8] == OP_RD_ADDR) &&  pending_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            op_q       <= OP_WR_ADDR;
            pending_q  <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            pending_q  <= pending_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !reject) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 4'd1;
                end
            end
            ST_CMD: begin
                if (bit_cnt_q == 4'd0) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'(FRAME_BITS - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                case (op_q)
                    OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR: begin
                        state_d    = ST_GAP;
                        wait_cnt_d = WAIT_W'(IDLE_GAP - 1);
                    end
                    default: begin
                        state_d    = ST_RD_WAIT;
                        wait_cnt_d = WAIT_W'(RD_LAT);
                    end
                endcase
            end
            ST_RD_WAIT: begin
                // The last RD_WAIT edge is the one where the slave shifts its dummy bit.
                if (wait_cnt_q == '0) begin
                    state_d   = ST_RD_SHIFT;
                    bit_cnt_d = 4'(DATA_BITS - 1);
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            ST_RD_SHIFT: begin
                if (bit_cnt_q == 4'd0) begin
                    state_d    = ST_GAP;
                    wait_cnt_d = WAIT_W'(IDLE_GAP - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        pending_d  = pending_q;
        tx_load    = (state_q == ST_IDLE) && (state_d == ST_CMD);
        tx_shift   = (state_q == ST_SHIFT);
        rx_shift   = (state_q == ST_RD_SHIFT);
        ss_n_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_GAP) && (state_q != ST_GAP);
        rd_valid_d = (state_q == ST_RD_SHIFT) && (state_d == ST_GAP);
        err_d      = (state_q == ST_IDLE) && start && reject;
        if (tx_load) begin
            op_d = din[9:8];
        end
        if ((state_q == ST_HOLD) && (state_d == ST_GAP) && (op_q == OP_RD_ADDR)) begin
            pending_d = 1'b1;
        end
        if (rd_valid_d) begin
            pending_d = 1'b0;
        end
    end

    // MOSI comes straight off the MSB: after the tenth shift only zeros remain.
    spi_shift_reg #(.DATA_W(FRAME_BITS)) u_tx_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .load_val (din),
        .shift_en (tx_shift),
        .sin      (1'b0),
        .sout     (MOSI),
        .q        (tx_par_unused)
    );

    spi_shift_reg #(.DATA_W(DATA_BITS)) u_rx_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_val ('0),
        .shift_en (rx_shift),
        .sin      (MISO),
        .sout     (rx_sout_unused),
        .q        (rd_data)
    );

    assign SS_n     = ss_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rd_valid = rd_valid_q;

endmodule
